// File: rtl/timestamp_run_sequencer.sv
// Run-window controller for the timestamp generator: arms, starts, stops, captures and drains.
// Optional macro TIMESTAMP_RUN_SEQUENCER_TRIG_SYNC_EN adds a two-flop synchronizer on ext_trig.
module timestamp_run_sequencer #(
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int DRAIN_CYCLES    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm,
  input  logic                       trig_mode,
  input  logic [TIMESTAMP_WIDTH-1:0] duration,
  input  logic                       sw_stop,
  input  logic                       ext_trig,
  input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
  output logic                       gen_run,
  output logic                       busy,
  output logic [1:0]                 state,
  output logic                       done,
  output logic [1:0]                 stop_cause,
  output logic [TIMESTAMP_WIDTH-1:0] stop_timestamp
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES);
  localparam logic [TIMESTAMP_WIDTH-1:0] TS_ONE = {{(TIMESTAMP_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]                 state_r;
  logic [1:0]                 state_nxt;
  logic [TIMESTAMP_WIDTH-1:0] dur_r;
  logic [TIMESTAMP_WIDTH-1:0] stop_timestamp_r;
  logic [1:0]                 stop_cause_r;
  logic [7:0]                 drain_cnt_r;
  logic                       gen_run_r;
  logic                       done_r;
  logic                       trig_event_s;
  logic                       dur_hit_s;
  logic                       drain_last_s;
  logic                       arm_take_s;
  logic                       capture_s;
  logic                       done_nxt_s;
  logic                       gen_run_nxt_s;

`ifdef TIMESTAMP_RUN_SEQUENCER_TRIG_SYNC_EN
  logic sync1_r;
  logic sync2_r;
  logic sync_prev_r;

  // Two-flop synchronizer followed by edge history; runs in every state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r     <= 1'b0;
      sync2_r     <= 1'b0;
      sync_prev_r <= 1'b0;
    end else begin
      sync1_r     <= ext_trig;
      sync2_r     <= sync1_r;
      sync_prev_r <= sync2_r;
    end
  end

  assign trig_event_s = sync2_r & ~sync_prev_r;
`else
  logic trig_prev_r;

  // Edge history on the already-synchronous trigger; runs in every state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_prev_r <= 1'b0;
    end else begin
      trig_prev_r <= ext_trig;
    end
  end

  assign trig_event_s = ext_trig & ~trig_prev_r;
`endif

  assign dur_hit_s    = (dur_r != '0) && (timestamp == (dur_r - TS_ONE));
  assign drain_last_s = (drain_cnt_r == DRAIN_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic; sw_stop outranks a same-cycle trigger in ARMED
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      S_IDLE: begin
        if (arm) begin
          state_nxt = trig_mode ? S_ARMED : S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ARMED: begin
        if (sw_stop) begin
          state_nxt = S_IDLE;
        end else if (trig_event_s) begin
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_ARMED;
        end
      end
      S_RUN: begin
        if (sw_stop || dur_hit_s) begin
          state_nxt = S_DRAIN;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        if (drain_last_s) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DRAIN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: strobes that feed the registered outputs
  always_comb begin
    arm_take_s    = (state_r == S_IDLE) && arm;
    capture_s     = (state_r == S_RUN) && (state_nxt == S_DRAIN);
    done_nxt_s    = (state_r == S_DRAIN) && (state_nxt == S_IDLE);
    gen_run_nxt_s = (state_nxt == S_RUN);
  end

  // Registered outputs, latched run parameters and drain counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gen_run_r        <= 1'b0;
      done_r           <= 1'b0;
      dur_r            <= '0;
      stop_cause_r     <= 2'b00;
      stop_timestamp_r <= '0;
      drain_cnt_r      <= 8'd0;
    end else begin
      gen_run_r <= gen_run_nxt_s;
      done_r    <= done_nxt_s;
      if (arm_take_s) begin
        dur_r <= duration;
      end
      if (capture_s) begin
        stop_cause_r     <= {sw_stop, dur_hit_s};
        stop_timestamp_r <= timestamp;
      end
      // Drain spans counts 0..DRAIN_CYCLES so done lands DRAIN_CYCLES+1 after drain entry
      if ((state_r == S_DRAIN) && !drain_last_s) begin
        drain_cnt_r <= drain_cnt_r + 8'd1;
      end else begin
        drain_cnt_r <= 8'd0;
      end
    end
  end

  assign gen_run        = gen_run_r;
  assign done           = done_r;
  assign busy           = (state_r != S_IDLE);
  assign state          = state_r;
  assign stop_cause     = stop_cause_r;
  assign stop_timestamp = stop_timestamp_r;

endmodule
